// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the config loader and the latch-bank generator.
// The CHECK state exists only when CFG_CHECKSUM_EN is defined.
package cfg_loader_pkg;

  localparam int CFG_WORD_W    = 32;
  localparam int CFG_NUM_WORDS = 43;
  localparam int CFG_CNT_W     = $clog2(CFG_NUM_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
`ifdef CFG_CHECKSUM_EN
    ST_CHECK  = 3'd5,
`endif
    ST_DONE   = 3'd6
  } cfg_ld_state_t;

endpackage

// File: rtl/configs_loader.sv
// Sequencer between the config bitstream source and the configs_latches bank.
// Each accepted word is presented on io_d_out for a full cycle before and
// after its one-hot enable pulse, so every latch word is written exactly once.
// Optional feature macro: CFG_CHECKSUM_EN adds a trailing checksum word, a
// modulo-2^WORD_W running sum register and the io_err output.
module configs_loader
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W    = CFG_WORD_W,
  parameter int NUM_WORDS = CFG_NUM_WORDS,
  parameter int CNT_W     = CFG_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_abort,
  input  logic [WORD_W-1:0]    io_word_in,
  input  logic                 io_word_valid,
  output logic                 io_word_ready,
  output logic [WORD_W-1:0]    io_d_out,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic                 io_busy,
  output logic                 io_done
`ifdef CFG_CHECKSUM_EN
  ,
  output logic                 io_err
`endif
);

  cfg_ld_state_t          state_q, state_d;
  logic [CNT_W-1:0]       index_q, index_d;
  logic [WORD_W-1:0]      d_out_q, d_out_d;
  logic [NUM_WORDS-1:0]   en_q, en_d;
`ifdef CFG_CHECKSUM_EN
  logic [WORD_W-1:0]      sum_q, sum_d;
  logic                   err_q, err_d;
`endif

  logic                   idle_or_done;
  logic                   word_ready;
  logic                   accept;
  logic                   last_word;
  logic [NUM_WORDS-1:0]   onehot;

  assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
  // Abort takes priority, so no word is consumed in the cycle it is raised.
`ifdef CFG_CHECKSUM_EN
  assign word_ready = ((state_q == ST_WAIT) || (state_q == ST_CHECK)) && !io_abort;
`else
  assign word_ready = (state_q == ST_WAIT) && !io_abort;
`endif
  assign accept     = io_word_valid && word_ready;
  assign last_word  = (index_q == CNT_W'(NUM_WORDS - 1));
  assign onehot     = {{(NUM_WORDS-1){1'b0}}, 1'b1} << index_q;

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      d_out_q <= '0;
      en_q    <= '0;
`ifdef CFG_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      d_out_q <= d_out_d;
      en_q    <= en_d;
`ifdef CFG_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic; abort returns to IDLE from anywhere.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (io_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (io_start) state_d = ST_WAIT;
        ST_WAIT:          if (accept)   state_d = ST_SETUP;
        ST_SETUP:         state_d = ST_STROBE;
        ST_STROBE:        state_d = ST_HOLD;
`ifdef CFG_CHECKSUM_EN
        ST_HOLD:          state_d = last_word ? ST_CHECK : ST_WAIT;
        ST_CHECK:         if (accept)   state_d = ST_DONE;
`else
        ST_HOLD:          state_d = last_word ? ST_DONE : ST_WAIT;
`endif
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath next values; the enable is decoded from the next state so the
  // pulse comes straight out of a flop and is glitch-free.
  always_comb begin
    index_d = index_q;
    d_out_d = d_out_q;
    en_d    = '0;
`ifdef CFG_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    if (!io_abort && idle_or_done && io_start) begin
      index_d = '0;
`ifdef CFG_CHECKSUM_EN
      sum_d   = '0;
      err_d   = 1'b0;
`endif
    end
    if ((state_q == ST_WAIT) && accept) begin
      d_out_d = io_word_in;
`ifdef CFG_CHECKSUM_EN
      sum_d   = sum_q + io_word_in;
`endif
    end
    // Index stops at the last word instead of wrapping.
    if (!io_abort && (state_q == ST_HOLD) && !last_word) begin
      index_d = index_q + CNT_W'(1);
    end
`ifdef CFG_CHECKSUM_EN
    if ((state_q == ST_CHECK) && accept) begin
      err_d = (io_word_in != sum_q);
    end
`endif
    if (state_d == ST_STROBE) begin
      en_d = onehot;
    end
  end

  assign io_word_ready = word_ready;
  assign io_d_out      = d_out_q;
  assign io_configs_en = en_q;
  assign io_busy       = !idle_or_done;
  assign io_done       = (state_q == ST_DONE);
`ifdef CFG_CHECKSUM_EN
  assign io_err        = err_q;
`endif

endmodule

// File: tb/tb_configs_loader.sv
// Self-checking bench for configs_loader: a reset/handshake vector table,
// directed load sequences and a randomized phase, all compared every cycle
// against a transaction-level model of the loader's timing rules.
module tb_configs_loader;

  localparam int NW  = 43;
  localparam int INF = 1 << 30;

  logic          clk;
  logic          reset;
  logic          io_start;
  logic          io_abort;
  logic [31:0]   io_word_in;
  logic          io_word_valid;
  logic          io_word_ready;
  logic [31:0]   io_d_out;
  logic [NW-1:0] io_configs_en;
  logic          io_busy;
  logic          io_done;
`ifdef CFG_CHECKSUM_EN
  logic          io_err;
`endif

  configs_loader dut (
    .clk           (clk),
    .reset         (reset),
    .io_start      (io_start),
    .io_abort      (io_abort),
    .io_word_in    (io_word_in),
    .io_word_valid (io_word_valid),
    .io_word_ready (io_word_ready),
    .io_d_out      (io_d_out),
    .io_configs_en (io_configs_en),
    .io_busy       (io_busy),
    .io_done       (io_done)
`ifdef CFG_CHECKSUM_EN
    ,
    .io_err        (io_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Transaction-level model: words accepted, when the next pulse / done is due.
  logic        m_active, m_done, m_err, m_chk;
  logic [31:0] m_word, m_sum;
  int          m_n, m_pulse_cyc, m_pulse_idx, m_done_cyc, m_ready_from;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_init();
    m_active = 0; m_done = 0; m_err = 0; m_chk = 0;
    m_word = '0; m_sum = '0; m_n = 0;
    m_pulse_cyc = -1; m_pulse_idx = -1; m_done_cyc = -1; m_ready_from = INF;
  endtask

  function automatic logic model_ready_now();
    return m_active && (cyc >= m_ready_from);
  endfunction

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic tick();
    logic          exp_rdy, acc, st, ab;
    logic [31:0]   w;
    logic [NW-1:0] exp_en;
    #1;
    exp_rdy = model_ready_now() && !io_abort;
    check("ready", 64'(io_word_ready), 64'(exp_rdy));
    acc = io_word_valid && exp_rdy;
    w = io_word_in; st = io_start; ab = io_abort;
    @(posedge clk);
    #1;
    cyc++;
    if (ab) begin
      m_active = 0; m_done = 0; m_pulse_cyc = -1; m_done_cyc = -1;
    end else if (st && !m_active) begin
      m_active = 1; m_done = 0; m_err = 0; m_chk = 0; m_sum = '0; m_n = 0;
      m_ready_from = cyc; m_done_cyc = -1;
    end else if (acc) begin
      if (m_chk) begin
        m_err = (w != m_sum); m_done_cyc = cyc; m_ready_from = INF; m_chk = 0;
      end else begin
        m_word = w; m_sum = m_sum + w;
        m_pulse_cyc = cyc + 1; m_pulse_idx = m_n; m_n++;
        if (m_n == NW) begin
`ifdef CFG_CHECKSUM_EN
          m_chk = 1; m_ready_from = cyc + 3;
`else
          m_done_cyc = cyc + 3; m_ready_from = INF;
`endif
        end else begin
          m_ready_from = cyc + 3;
        end
      end
    end
    if (m_active && cyc == m_done_cyc) begin
      m_active = 0; m_done = 1;
    end
    exp_en = '0;
    if (cyc == m_pulse_cyc) exp_en[m_pulse_idx] = 1'b1;
    check("configs_en", 64'(io_configs_en), 64'(exp_en));
    check("d_out",      64'(io_d_out),      64'(m_word));
    check("busy",       64'(io_busy),       64'(m_active));
    check("done",       64'(io_done),       64'(m_done));
`ifdef CFG_CHECKSUM_EN
    check("err",        64'(io_err),        64'(m_err));
`endif
  endtask

  // Off-edge asynchronous reset; outputs must clear before any clock edge.
  task automatic do_reset();
    io_start = 0; io_abort = 0; io_word_valid = 0; io_word_in = '0;
    #2 reset = 1'b0;
    #1;
    check("rst configs_en", 64'(io_configs_en), 64'd0);
    check("rst d_out",      64'(io_d_out),      64'd0);
    check("rst busy",       64'(io_busy),       64'd0);
    check("rst done",       64'(io_done),       64'd0);
    check("rst ready",      64'(io_word_ready), 64'd0);
`ifdef CFG_CHECKSUM_EN
    check("rst err",        64'(io_err),        64'd0);
`endif
    model_init();
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
  endtask

  // Run one load with valid held high, optionally with a valid gap, an abort
  // during the STROBE of a given word, or a spurious start at a given word.
  task automatic stream(input int gap_at, input int abort_at, input int restart_at,
                        input logic use_idx, input logic [31:0] chk_word,
                        output int t0, output int tdone, output int pulses);
    int   gap;
    logic restarted;
    gap = 10; restarted = 0; t0 = -1; tdone = -1; pulses = 0;
    io_start = 1; io_word_valid = 0; tick(); io_start = 0;
    for (int b = 0; b < 400; b++) begin
      io_word_valid = 1'b1;
      io_word_in = m_chk ? chk_word : (use_idx ? 32'(m_n) : 32'h1);
      if (m_n == gap_at && gap > 0 && model_ready_now()) begin
        io_word_valid = 1'b0; gap--;
      end
      if (m_n == restart_at && !restarted) begin
        io_start = 1; restarted = 1;
      end
      if (t0 < 0 && io_word_valid && model_ready_now()) t0 = cyc;
      tick();
      io_start = 0;
      if (io_configs_en != '0) pulses++;
      if (m_pulse_idx == abort_at && m_pulse_cyc == cyc) begin
        io_abort = 1; tick(); io_abort = 0;
        break;
      end
      if (m_done) begin
        tdone = cyc;
        break;
      end
    end
    io_word_valid = 0;
  endtask

  typedef struct {
    logic          start, abort, valid;
    logic [31:0]   word;
    logic          exp_ready, exp_busy, exp_done;
    logic [NW-1:0] exp_en;
    logic [31:0]   exp_dout;
  } row_t;

  row_t rows[9];
  int   t0, tdone, pulses;

  initial begin
    reset = 1'b1;
    io_start = 0; io_abort = 0; io_word_valid = 0; io_word_in = '0;

    // start, abort, valid, word, ready(pre-edge), busy, done, en, d_out (post-edge)
    rows[0] = '{1'b0, 1'b0, 1'b1, 32'hAA, 1'b0, 1'b0, 1'b0, NW'(0), 32'h00};
    rows[1] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, NW'(0), 32'h00};
    rows[2] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, NW'(0), 32'h00};
    rows[3] = '{1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 1'b0, NW'(0), 32'h11};
    rows[4] = '{1'b0, 1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0, NW'(1), 32'h11};
    rows[5] = '{1'b1, 1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0, NW'(0), 32'h11};
    rows[6] = '{1'b0, 1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0, NW'(0), 32'h11};
    rows[7] = '{1'b0, 1'b1, 1'b1, 32'h33, 1'b0, 1'b0, 1'b0, NW'(0), 32'h11};
    rows[8] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, NW'(0), 32'h11};

    do_reset();

    for (int i = 0; i < 9; i++) begin
      io_start = rows[i].start; io_abort = rows[i].abort;
      io_word_valid = rows[i].valid; io_word_in = rows[i].word;
      #1;
      check($sformatf("row%0d ready", i), 64'(io_word_ready), 64'(rows[i].exp_ready));
      @(posedge clk);
      #1;
      check($sformatf("row%0d busy", i),  64'(io_busy),       64'(rows[i].exp_busy));
      check($sformatf("row%0d done", i),  64'(io_done),       64'(rows[i].exp_done));
      check($sformatf("row%0d en", i),    64'(io_configs_en), 64'(rows[i].exp_en));
      check($sformatf("row%0d d_out", i), 64'(io_d_out),      64'(rows[i].exp_dout));
    end

    do_reset();

    // Full load, words = index, valid held high.
    stream(-1, -1, -1, 1'b1, 32'h0, t0, tdone, pulses);
    check("t1 pulses", 64'(pulses), 64'(NW));
`ifdef CFG_CHECKSUM_EN
    check("t1 done latency", 64'(tdone - t0), 64'd173);
`else
    check("t1 done latency", 64'(tdone - t0), 64'd172);
`endif

    // Valid gap of 10 ready cycles while word 5 is due.
    stream(5, -1, -1, 1'b1, 32'h0, t0, tdone, pulses);
`ifdef CFG_CHECKSUM_EN
    check("t2 done latency", 64'(tdone - t0), 64'd183);
`else
    check("t2 done latency", 64'(tdone - t0), 64'd182);
`endif

    // Abort during the STROBE of word 20, then a clean restart.
    stream(-1, 20, -1, 1'b1, 32'h0, t0, tdone, pulses);
    check("t3 pulses before abort", 64'(pulses), 64'd21);
    check("t3 aborted busy", 64'(io_busy), 64'd0);
    check("t3 aborted done", 64'(io_done), 64'd0);
    stream(-1, -1, -1, 1'b1, 32'h0, t0, tdone, pulses);
    check("t3 restart pulses", 64'(pulses), 64'(NW));

    // Start pulsed while busy at word 10 is ignored.
    stream(-1, -1, 10, 1'b1, 32'h0, t0, tdone, pulses);
    check("t4 pulses", 64'(pulses), 64'(NW));
    check("t4 finished", 64'(tdone > 0), 64'd1);

`ifdef CFG_CHECKSUM_EN
    stream(-1, -1, -1, 1'b0, 32'h2B, t0, tdone, pulses);
    check("t5 good sum err", 64'(io_err), 64'd0);
    check("t5 good sum done", 64'(io_done), 64'd1);
    check("t5 good sum pulses", 64'(pulses), 64'(NW));
    stream(-1, -1, -1, 1'b0, 32'h2C, t0, tdone, pulses);
    check("t5 bad sum err", 64'(io_err), 64'd1);
    check("t5 bad sum done", 64'(io_done), 64'd1);
`endif

    // Async reset asserted off-edge in the middle of a STROBE.
    io_start = 1; tick(); io_start = 0;
    for (int b = 0; b < 50 && cyc != m_pulse_cyc; b++) begin
      io_word_valid = 1; io_word_in = 32'hCAFE_0000 + 32'(m_n);
      tick();
    end
    check("t6 strobe reached", 64'(io_configs_en != '0), 64'd1);
    do_reset();
    tick();
    io_start = 1; tick(); io_start = 0;
    check("t6 restart from idle", 64'(io_word_ready), 64'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      io_start      = ($urandom_range(0, 19) == 0);
      io_abort      = ($urandom_range(0, 299) == 0);
      io_word_valid = ($urandom_range(0, 3) != 0);
      io_word_in    = $urandom;
      tick();
    end
    io_start = 0; io_abort = 0; io_word_valid = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
